// File: rtl/fir_mc_pkg.sv
// +--------------------------------------------------------------------------+
// | Module      : fir_mc_pkg                                                 |
// | Description : Shared types and helpers for the multichannel FIR MAC:     |
// |               FSM state encoding, derived-width functions and the        |
// |               output saturation helper.                                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

package fir_mc_pkg;

  // FSM encoding shared by the top level and anything that observes it
  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    MAC   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Working width of the saturation helper; wide enough for any sane accumulator
  localparam int SAT_W = 64;

  // Channel tag width: at least one bit even for a single channel
  function automatic int cw_of(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  // Accumulator width: full product plus growth for LENGTH additions
  function automatic int acc_w_of(input int width, input int length);
    return 2 * width + $clog2(length);
  endfunction

  // Clamp a sign-extended value into the signed range of 'width' bits
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                        input int width);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (width - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fir_multichannel_mac_history_ram.sv
// +--------------------------------------------------------------------------+
// | Module      : fir_history_ram                                            |
// | Description : Sample history store, one write port and one asynchronous  |
// |               read port, addressed as {channel, index}.                  |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module fir_history_ram #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Single write port; the newest sample must be readable on the very next cycle
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/fir_multichannel_mac.sv
// +--------------------------------------------------------------------------+
// | Module      : fir_multichannel_mac                                       |
// | Description : Time-multiplexed single-MAC FIR. CHANNELS independent      |
// |               histories share one runtime-loadable tap set. One result   |
// |               per accepted sample, LENGTH MAC cycles per sample.         |
// |               Build option OUT_SAT_EN: clamp the output instead of       |
// |               wrapping it to WIDTH bits.                                 |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`default_nettype none

module fir_multichannel_mac
  import fir_mc_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int LENGTH   = 64,
  parameter  int CHANNELS = 4,
  localparam int CW       = cw_of(CHANNELS),
  localparam int AW       = $clog2(LENGTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [CW-1:0]    channel_in,
  input  logic             input_valid,
  output logic             input_ready,
  input  logic             coef_wr,
  input  logic [AW-1:0]    coef_addr,
  input  logic [WIDTH-1:0] coef_data,
  output logic [WIDTH-1:0] data_out,
  output logic [CW-1:0]    channel_out,
  output logic             output_valid
);

  localparam int             ACC_W    = acc_w_of(WIDTH, LENGTH);
  localparam int             NPTR     = 1 << CW;
  localparam int             HDEPTH   = CHANNELS << AW;
  localparam logic [AW-1:0]  LAST_TAP = AW'(LENGTH - 1);
  localparam logic [AW:0]    LEN_EXT  = (AW + 1)'(LENGTH);
  localparam logic [CW-1:0]  LAST_CH  = CW'(CHANNELS - 1);

  state_t                    state;
  state_t                    state_nxt;
  logic                      accept;
  logic                      coef_we;
  logic                      ch_ok;
  logic                      coef_addr_ok;
  logic                      clr_last;
  logic [AW-1:0]             tap;
  logic [AW-1:0]             clr_idx;
  logic [CW-1:0]             clr_ch;
  logic [CW-1:0]             cur_ch;
  logic [AW-1:0]             ptr [NPTR];
  logic [AW-1:0]             ptr_cur;
  logic [AW-1:0]             rd_idx;
  logic signed [WIDTH-1:0]   coef [LENGTH];
  logic signed [ACC_W-1:0]   acc;
  logic signed [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]          hist_rd;
  logic [WIDTH-1:0]          hist_wdata;
  logic                      hist_we;
  logic [CW+AW-1:0]          hist_waddr;
  logic [CW+AW-1:0]          hist_raddr;
  logic [WIDTH-1:0]          data_nxt;

  // Tags beyond the last channel complete the handshake but are dropped
  assign ch_ok        = 32'(channel_in) < 32'(CHANNELS);
  assign coef_addr_ok = 32'(coef_addr) < 32'(LENGTH);
  assign clr_last     = (clr_idx == LAST_TAP) && (clr_ch == LAST_CH);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state, handshake and coefficient-write qualification
  always_comb begin
    state_nxt   = state;
    input_ready = 1'b0;
    accept      = 1'b0;
    coef_we     = 1'b0;
    case (state)
      CLEAR: begin
        if (clr_last) begin
          state_nxt = IDLE;
        end
      end
      IDLE: begin
        // A coefficient write takes the cycle; the sample waits one cycle
        input_ready = ~coef_wr;
        coef_we     = coef_wr;
        if (input_valid && !coef_wr) begin
          accept = 1'b1;
          if (ch_ok) begin
            state_nxt = MAC;
          end
        end
      end
      MAC: begin
        if (tap == LAST_TAP) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = CLEAR;
      end
    endcase
  end

  // Circular history index of tap k: (ptr - k) mod LENGTH
  always_comb begin
    ptr_cur = ptr[cur_ch];
    if (ptr_cur >= tap) begin
      rd_idx = ptr_cur - tap;
    end else begin
      rd_idx = AW'({1'b0, ptr_cur} + LEN_EXT - {1'b0, tap});
    end
  end

  // History write source: zero-fill while clearing, otherwise the accepted sample
  always_comb begin
    hist_we    = 1'b0;
    hist_waddr = {clr_ch, clr_idx};
    hist_wdata = '0;
    if (state == CLEAR) begin
      hist_we = 1'b1;
    end else if (accept && ch_ok) begin
      hist_we    = 1'b1;
      hist_waddr = {channel_in, ptr[channel_in]};
      hist_wdata = data_in;
    end
  end

  assign hist_raddr = {cur_ch, rd_idx};

  fir_history_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (CW + AW),
    .DEPTH  (HDEPTH)
  ) u_hist (
    .clk    (clk),
    .we     (hist_we),
    .waddr  (hist_waddr),
    .wdata  (hist_wdata),
    .raddr  (hist_raddr),
    .rdata  (hist_rd)
  );

  assign prod = coef[tap] * $signed(hist_rd);

`ifdef OUT_SAT_EN
  logic signed [SAT_W-1:0] sat_full;

  // Scale back to Q1.(WIDTH-1) and clamp to the representable range
  always_comb begin
    sat_full = saturate(SAT_W'(acc >>> (WIDTH - 1)), WIDTH);
    data_nxt = WIDTH'(sat_full);
  end
`else
  // Scale back to Q1.(WIDTH-1) and keep the low WIDTH bits
  always_comb begin
    data_nxt = WIDTH'(acc >>> (WIDTH - 1));
  end
`endif

  // Coefficient store: not reset, writable only while idle
  always_ff @(posedge clk) begin
    if (coef_we && coef_addr_ok) begin
      coef[coef_addr] <= $signed(coef_data);
    end
  end

  // Clear sweep, tap sequencing, accumulation, pointers and result register
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_idx      <= '0;
      clr_ch       <= '0;
      tap          <= '0;
      cur_ch       <= '0;
      acc          <= '0;
      data_out     <= '0;
      channel_out  <= '0;
      output_valid <= 1'b0;
      for (int i = 0; i < NPTR; i++) begin
        ptr[i] <= '0;
      end
    end else begin
      output_valid <= 1'b0;
      case (state)
        CLEAR: begin
          tap <= '0;
          for (int i = 0; i < NPTR; i++) begin
            ptr[i] <= '0;
          end
          if (clr_idx == LAST_TAP) begin
            clr_idx <= '0;
            clr_ch  <= clr_last ? '0 : clr_ch + 1'b1;
          end else begin
            clr_idx <= clr_idx + 1'b1;
          end
        end
        IDLE: begin
          if (accept && ch_ok) begin
            cur_ch <= channel_in;
            acc    <= '0;
            tap    <= '0;
          end
        end
        MAC: begin
          acc <= acc + ACC_W'(prod);
          tap <= (tap == LAST_TAP) ? '0 : tap + 1'b1;
        end
        DONE: begin
          data_out     <= data_nxt;
          channel_out  <= cur_ch;
          output_valid <= 1'b1;
          ptr[cur_ch]  <= (ptr[cur_ch] == LAST_TAP) ? '0 : ptr[cur_ch] + 1'b1;
        end
        default: begin
          tap <= '0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
